// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS32 front pipeline: opcodes, functs,
// ALU-control codes and the bit positions inside the control bundles.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALUOp field carried from ID into EX
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operation selected in EX
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_e;

  // EX control bundle: {RegDst, ALUSrc, ALUOp[1:0]}
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUSRC    = 2;
  localparam int EX_ALUOP_MSB = 1;
  localparam int EX_ALUOP_LSB = 0;

  // MEM control bundle: {MemRead, MemWrite}
  localparam int MEM_READ  = 1;
  localparam int MEM_WRITE = 0;

  // WB control bundle: {RegWrite, MemtoReg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Sign-extend a 16-bit immediate to 32 bits
  function automatic logic [31:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port,
// r0 hardwired to zero, and a write-to-read bypass so a value written by
// WB in this cycle is visible to ID in the same cycle.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  // Register write; reset clears every entry
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the array is reset on purpose (registers must read 0 after
      // reset), which keeps it as flops rather than an inferred RAM.
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Read ports with r0 forced to zero and same-cycle write bypass
  assign rd1 = (ra1 == 5'd0)             ? 32'd0 :
               (we && (wa == ra1))        ? wd    : regs[ra1];
  assign rd2 = (ra2 == 5'd0)             ? 32'd0 :
               (we && (wa == ra2))        ? wd    : regs[ra2];

endmodule

// File: rtl/mips_front_pipeline.sv
// IF, ID and EX stages of a 5-stage MIPS32 integer pipeline. Branches and
// jumps resolve in ID with one architectural delay slot; the EX/MEM
// register is driven straight onto the ex_* outputs for the MEM stage.
module mips_front_pipeline
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_addr,
  input  logic [31:0] wb_data,
  output logic        id_pcsrc,
  output logic [31:0] id_branch_pc,
  output logic [31:0] ex_alu_result,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_write_addr,
  output logic [1:0]  ex_mem_ctrl,
  output logic [1:0]  ex_wb_ctrl
);

  // ---------------- IF ----------------
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Program counter: redirect from ID or fall through
  always_ff @(posedge Clk) begin
    if (Rst)           pc <= RESET_PC;
    else if (id_pcsrc) pc <= id_branch_pc;
    else               pc <= pc_plus4;
  end

  // IF/ID register; all-zero instruction decodes as a NOP
  always_ff @(posedge Clk) begin
    if (Rst) begin
      if_id_pc4   <= '0;
      if_id_instr <= '0;
    end else begin
      if_id_pc4   <= pc_plus4;
      if_id_instr <= imem_rdata;
    end
  end

  // ---------------- ID ----------------
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] id_se;
  logic [31:0] id_a, id_b;
  logic [3:0]  id_ex_ctl;
  logic [1:0]  id_mem_ctl;
  logic [1:0]  id_wb_ctl;
  logic        is_beq, is_j;
  logic [31:0] branch_tgt, jump_tgt;

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];
  assign funct  = if_id_instr[5:0];
  assign id_se  = sign_ext(if_id_instr[15:0]);

  mips_regfile u_regfile (
    .clk (Clk),
    .rst (Rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (id_a),
    .rd2 (id_b),
    .we  (wb_reg_write),
    .wa  (wb_write_addr),
    .wd  (wb_data)
  );

  // Main decoder: anything unrecognised leaves all control bits at 0
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    id_ex_ctl  = '0;
    id_mem_ctl = '0;
    id_wb_ctl  = '0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            id_ex_ctl[EX_REGDST]                  = 1'b1;
            id_ex_ctl[EX_ALUOP_MSB:EX_ALUOP_LSB]  = ALUOP_FUNCT;
            id_wb_ctl[WB_REGWRITE]                = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LW: begin
        id_ex_ctl[EX_ALUSRC]   = 1'b1;
        id_mem_ctl[MEM_READ]   = 1'b1;
        id_wb_ctl[WB_REGWRITE] = 1'b1;
        id_wb_ctl[WB_MEMTOREG] = 1'b1;
      end
      OP_SW: begin
        id_ex_ctl[EX_ALUSRC]  = 1'b1;
        id_mem_ctl[MEM_WRITE] = 1'b1;
      end
      OP_ADDI: begin
        id_ex_ctl[EX_ALUSRC]   = 1'b1;
        id_wb_ctl[WB_REGWRITE] = 1'b1;
      end
      OP_BEQ:  is_beq = 1'b1;
      OP_J:    is_j   = 1'b1;
      default: ;
    endcase
  end

  assign branch_tgt   = if_id_pc4 + {id_se[29:0], 2'b00};
  assign jump_tgt     = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
  assign id_pcsrc     = (is_beq && (id_a == id_b)) || is_j;
  assign id_branch_pc = is_j ? jump_tgt : branch_tgt;

  // ---------------- ID/EX ----------------
  logic [31:0] id_ex_a, id_ex_b, id_ex_se;
  logic [4:0]  id_ex_rt, id_ex_rd;
  logic [5:0]  id_ex_funct;
  logic [3:0]  id_ex_exc;
  logic [1:0]  id_ex_mem, id_ex_wb;

  // ID/EX register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      id_ex_a     <= '0;
      id_ex_b     <= '0;
      id_ex_se    <= '0;
      id_ex_rt    <= '0;
      id_ex_rd    <= '0;
      id_ex_funct <= '0;
      id_ex_exc   <= '0;
      id_ex_mem   <= '0;
      id_ex_wb    <= '0;
    end else begin
      id_ex_a     <= id_a;
      id_ex_b     <= id_b;
      id_ex_se    <= id_se;
      id_ex_rt    <= rt;
      id_ex_rd    <= rd;
      id_ex_funct <= funct;
      id_ex_exc   <= id_ex_ctl;
      id_ex_mem   <= id_mem_ctl;
      id_ex_wb    <= id_wb_ctl;
    end
  end

  // ---------------- EX ----------------
  alu_ctl_e    alu_ctl;
  logic        funct_bad;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [1:0]  ex_wb_next;

  // ALU control; an unknown funct falls back to ADD and suppresses RegWrite
  always_comb begin
    alu_ctl   = ALU_ADD;
    funct_bad = 1'b0;
    case (id_ex_exc[EX_ALUOP_MSB:EX_ALUOP_LSB])
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (id_ex_funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: begin
            alu_ctl   = ALU_ADD;
            funct_bad = 1'b1;
          end
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

  assign alu_b = id_ex_exc[EX_ALUSRC] ? id_ex_se : id_ex_b;

  // ALU datapath; arithmetic wraps, slt compares as signed
  always_comb begin
    alu_y = '0;
    case (alu_ctl)
      ALU_AND: alu_y = id_ex_a & alu_b;
      ALU_OR:  alu_y = id_ex_a | alu_b;
      ALU_ADD: alu_y = id_ex_a + alu_b;
      ALU_SUB: alu_y = id_ex_a - alu_b;
      ALU_SLT: alu_y = {31'd0, ($signed(id_ex_a) < $signed(alu_b))};
      default: alu_y = id_ex_a + alu_b;
    endcase
  end

  assign ex_wb_next = {id_ex_wb[WB_REGWRITE] & ~funct_bad, id_ex_wb[WB_MEMTOREG]};

  // EX/MEM register, presented directly on the ex_* outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_alu_result <= '0;
      ex_store_data <= '0;
      ex_write_addr <= '0;
      ex_mem_ctrl   <= '0;
      ex_wb_ctrl    <= '0;
    end else begin
      ex_alu_result <= alu_y;
      ex_store_data <= id_ex_b;
      ex_write_addr <= id_ex_exc[EX_REGDST] ? id_ex_rd : id_ex_rt;
      ex_mem_ctrl   <= id_ex_mem;
      ex_wb_ctrl    <= ex_wb_next;
    end
  end

endmodule

// File: tb/tb_mips_front_pipeline.sv
// Self-checking bench for mips_front_pipeline. A behavioural model executes
// each instruction from its architectural meaning when it sits in ID, and
// plays the MEM and WB stages (with a small data memory) to close the loop
// back into the wb_* port.
module tb_mips_front_pipeline;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  wa;
    logic [1:0]  mem;
    logic [1:0]  wb;
  } exp_t;

  localparam int HIST = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata;
  logic        wb_reg_write;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_data;
  logic        id_pcsrc;
  logic [31:0] id_branch_pc;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_write_addr;
  logic [1:0]  ex_mem_ctrl, ex_wb_ctrl;

  mips_front_pipeline #(.RESET_PC(32'h0000_0000)) dut (
    .Clk           (clk),
    .Rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .wb_reg_write  (wb_reg_write),
    .wb_write_addr (wb_write_addr),
    .wb_data       (wb_data),
    .id_pcsrc      (id_pcsrc),
    .id_branch_pc  (id_branch_pc),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_write_addr (ex_write_addr),
    .ex_mem_ctrl   (ex_mem_ctrl),
    .ex_wb_ctrl    (ex_wb_ctrl)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [256];
  assign imem_rdata = rom[imem_addr[9:2]];

  // Write-back source: model MEM/WB loopback, or a directed forced write
  logic        force_wb, f_we;
  logic [4:0]  f_addr;
  logic [31:0] f_data;
  logic        m_wb_we;
  logic [4:0]  m_wb_addr;
  logic [31:0] m_wb_data;
  assign wb_reg_write  = force_wb ? f_we   : m_wb_we;
  assign wb_write_addr = force_wb ? f_addr : m_wb_addr;
  assign wb_data       = force_wb ? f_data : m_wb_data;

  // Model state
  logic [31:0] m_pc, m_ifid_pc4, m_ifid_instr;
  exp_t        m_idex, m_exmem;
  logic [31:0] regs [32];
  logic [31:0] dmem [256];

  int tests = 0;
  int fails = 0;

  logic [31:0] hist_addr [HIST];
  logic [31:0] hist_res  [HIST];
  logic [31:0] hist_sd   [HIST];
  logic [31:0] hist_wa   [HIST];
  logic [31:0] hist_mem  [HIST];
  logic [31:0] hist_wb   [HIST];
  logic [31:0] hist_pcs  [HIST];
  logic [31:0] hist_bpc  [HIST];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd_,
                                        input logic [4:0] rs_, input logic [4:0] rt_);
    return {6'h00, rs_, rt_, rd_, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt_,
                                        input logic [4:0] rs_, input logic [15:0] imm);
    return {op, rs_, rt_, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Architectural register read as seen by ID (r0 = 0, WB value visible)
  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_reg_write && (wb_write_addr == r)) return wb_data;
    return regs[r];
  endfunction

  // Meaning of one instruction: its EX/MEM outcome and any redirect
  task automatic ref_exec(input logic [31:0] instr, input logic [31:0] pc4,
                          output exp_t e, output logic pcs, output logic [31:0] tgt);
    logic [31:0] a, b, se;
    a  = rd_reg(instr[25:21]);
    b  = rd_reg(instr[20:16]);
    se = {{16{instr[15]}}, instr[15:0]};
    // No control bits: data still flows as A+B into rt, nothing committed
    e   = '{res: a + b, sd: b, wa: instr[20:16], mem: 2'b00, wb: 2'b00};
    pcs = 1'b0;
    tgt = 32'd0;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h20: e = '{res: a + b, sd: b, wa: instr[15:11], mem: 2'b00, wb: 2'b10};
          6'h22: e = '{res: a - b, sd: b, wa: instr[15:11], mem: 2'b00, wb: 2'b10};
          6'h24: e = '{res: a & b, sd: b, wa: instr[15:11], mem: 2'b00, wb: 2'b10};
          6'h25: e = '{res: a | b, sd: b, wa: instr[15:11], mem: 2'b00, wb: 2'b10};
          6'h2A: e = '{res: ($signed(a) < $signed(b)) ? 32'd1 : 32'd0, sd: b,
                       wa: instr[15:11], mem: 2'b00, wb: 2'b10};
          default: ;
        endcase
      end
      6'h23: e = '{res: a + se, sd: b, wa: instr[20:16], mem: 2'b10, wb: 2'b11};
      6'h2B: e = '{res: a + se, sd: b, wa: instr[20:16], mem: 2'b01, wb: 2'b00};
      6'h08: e = '{res: a + se, sd: b, wa: instr[20:16], mem: 2'b00, wb: 2'b10};
      6'h04: begin
        pcs = (a == b);
        tgt = pc4 + (se << 2);
      end
      6'h02: begin
        pcs = 1'b1;
        tgt = {pc4[31:28], instr[25:0], 2'b00};
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_pc         = 32'd0;
    m_ifid_pc4   = 32'd0;
    m_ifid_instr = 32'd0;
    m_idex       = '0;
    m_exmem      = '0;
    m_wb_we      = 1'b0;
    m_wb_addr    = 5'd0;
    m_wb_data    = 32'd0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
  endtask

  // One clock cycle: check all outputs at the falling edge, then advance the model
  task automatic step(input logic rst_next, input int cyc);
    exp_t        nx;
    logic        pcs;
    logic [31:0] tgt;
    logic        we_s;
    logic [4:0]  wa_s;
    logic [31:0] wd_s;
    @(negedge clk);
    ref_exec(m_ifid_instr, m_ifid_pc4, nx, pcs, tgt);
    check("imem_addr", imem_addr, m_pc);
    check("id_pcsrc", {31'd0, id_pcsrc}, {31'd0, pcs});
    if (pcs) check("id_branch_pc", id_branch_pc, tgt);
    check("ex_alu_result", ex_alu_result, m_exmem.res);
    check("ex_store_data", ex_store_data, m_exmem.sd);
    check("ex_write_addr", {27'd0, ex_write_addr}, {27'd0, m_exmem.wa});
    check("ex_mem_ctrl", {30'd0, ex_mem_ctrl}, {30'd0, m_exmem.mem});
    check("ex_wb_ctrl", {30'd0, ex_wb_ctrl}, {30'd0, m_exmem.wb});
    if (cyc >= 0 && cyc < HIST) begin
      hist_addr[cyc] = imem_addr;
      hist_res[cyc]  = ex_alu_result;
      hist_sd[cyc]   = ex_store_data;
      hist_wa[cyc]   = {27'd0, ex_write_addr};
      hist_mem[cyc]  = {30'd0, ex_mem_ctrl};
      hist_wb[cyc]   = {30'd0, ex_wb_ctrl};
      hist_pcs[cyc]  = {31'd0, id_pcsrc};
      hist_bpc[cyc]  = id_branch_pc;
    end
    we_s = wb_reg_write;
    wa_s = wb_write_addr;
    wd_s = wb_data;
    rst  = rst_next;
    @(posedge clk);
    #1;
    if (rst_next) begin
      model_reset();
    end else begin
      if (we_s && wa_s != 5'd0) regs[wa_s] = wd_s;
      m_wb_we   = m_exmem.wb[1];
      m_wb_addr = m_exmem.wa;
      m_wb_data = m_exmem.wb[0] ? dmem[m_exmem.res[9:2]] : m_exmem.res;
      if (m_exmem.mem[0]) dmem[m_exmem.res[9:2]] = m_exmem.sd;
      m_exmem      = m_idex;
      m_idex       = nx;
      m_ifid_pc4   = m_pc + 32'd4;
      m_ifid_instr = rom[m_pc[9:2]];
      m_pc         = pcs ? tgt : m_pc + 32'd4;
    end
  endtask

  // Hold reset for two edges and check the cleared state
  task automatic do_reset();
    rst      = 1'b1;
    force_wb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_alu_result", ex_alu_result, 32'd0);
    check("rst_store_data", ex_store_data, 32'd0);
    check("rst_write_addr", {27'd0, ex_write_addr}, 32'd0);
    check("rst_ctrl", {28'd0, ex_mem_ctrl, ex_wb_ctrl}, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] r1, r2, r3;
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    r3 = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 11))
      0, 1, 2, 3, 4: return enc_r(fns[$urandom_range(0, 4)], r1, r2, r3);
      5:  return enc_r(6'($urandom), r1, r2, r3);
      6:  return enc_i(6'h23, r1, r2, 16'($urandom));
      7:  return enc_i(6'h2B, r1, r2, 16'($urandom));
      8:  return enc_i(6'h08, r1, r2, 16'($urandom));
      9:  return enc_i(6'h04, r1, r2, 16'($signed($urandom_range(0, 16)) - 8));
      10: return enc_j(26'($urandom_range(0, 255)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    force_wb = 1'b0; f_we = 1'b0; f_addr = 5'd0; f_data = 32'd0;
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
    model_reset();

    // ---- Directed program: arithmetic, store, branch, jump, slt, sub, lw ----
    rom[0]  = enc_i(6'h08, 5'd1, 5'd0, 16'd5);        // addi r1,r0,5
    rom[1]  = enc_i(6'h08, 5'd2, 5'd0, 16'hFFFD);     // addi r2,r0,-3
    rom[2]  = enc_i(6'h08, 5'd7, 5'd0, 16'hFFFF);     // addi r7,r0,-1
    rom[3]  = enc_i(6'h08, 5'd8, 5'd0, 16'd1);        // addi r8,r0,1
    rom[4]  = enc_i(6'h04, 5'd0, 5'd0, 16'd4);        // 0x10 beq r0,r0,+4
    rom[5]  = enc_r(6'h20, 5'd3, 5'd1, 5'd2);         // 0x14 add r3,r1,r2 (delay slot)
    rom[6]  = enc_i(6'h08, 5'd20, 5'd0, 16'd99);      // skipped
    rom[9]  = enc_i(6'h2B, 5'd1, 5'd0, 16'd8);        // 0x24 sw r1,8(r0)
    rom[10] = enc_j(26'h40);                          // 0x28 j 0x100
    rom[11] = enc_i(6'h08, 5'd9, 5'd0, 16'd7);        // 0x2c addi r9,r0,7 (delay slot)
    rom[64] = enc_i(6'h08, 5'd10, 5'd0, 16'd9);       // 0x100 addi r10,r0,9
    rom[65] = enc_r(6'h2A, 5'd11, 5'd7, 5'd8);        // 0x104 slt r11,r7,r8
    rom[68] = enc_r(6'h22, 5'd12, 5'd9, 5'd10);       // 0x110 sub r12,r9,r10
    rom[69] = enc_i(6'h23, 5'd13, 5'd0, 16'd8);       // 0x114 lw r13,8(r0)
    rom[72] = enc_r(6'h20, 5'd14, 5'd13, 5'd0);       // 0x120 add r14,r13,r0
    rom[73] = enc_r(6'h3F, 5'd14, 5'd1, 5'd2);        // 0x124 unknown funct
    rom[74] = enc_i(6'h04, 5'd2, 5'd1, 16'd8);        // 0x128 beq r1,r2 (not taken)

    do_reset();
    for (int c = 0; c < 24; c++) step(1'b0, c);

    check("fetch_0", hist_addr[0], 32'h0);
    check("fetch_4", hist_addr[1], 32'h4);
    check("fetch_8", hist_addr[2], 32'h8);
    check("addi5_res", hist_res[3], 32'd5);
    check("addi5_wa", hist_wa[3], 32'd1);
    check("addi5_wb", hist_wb[3], 32'b10);
    check("addim3_res", hist_res[4], 32'hFFFF_FFFD);
    check("addim3_wa", hist_wa[4], 32'd2);
    check("beq_pcsrc", hist_pcs[5], 32'd1);
    check("beq_target", hist_bpc[5], 32'h24);
    check("delay_slot_fetch", hist_addr[5], 32'h14);
    check("branch_fetch", hist_addr[6], 32'h24);
    check("add_res", hist_res[8], 32'd2);
    check("add_wa", hist_wa[8], 32'd3);
    check("add_wb", hist_wb[8], 32'b10);
    check("sw_res", hist_res[9], 32'd8);
    check("sw_data", hist_sd[9], 32'd5);
    check("sw_mem", hist_mem[9], 32'b01);
    check("sw_wb", hist_wb[9], 32'b00);
    check("j_pcsrc", hist_pcs[8], 32'd1);
    check("j_target", hist_bpc[8], 32'h100);
    check("j_fetch", hist_addr[9], 32'h100);
    check("slt_res", hist_res[13], 32'd1);
    check("sub_res", hist_res[16], 32'hFFFF_FFFE);
    check("sub_wa", hist_wa[16], 32'd12);
    check("lw_res", hist_res[17], 32'd8);
    check("lw_mem", hist_mem[17], 32'b10);
    check("lw_wb", hist_wb[17], 32'b11);
    check("lw_use", hist_res[20], 32'd5);
    check("badfn_res", hist_res[21], 32'd2);
    check("badfn_wa", hist_wa[21], 32'd2);
    check("badfn_wb", hist_wb[21], 32'b00);
    check("beq_nt_pcsrc", hist_pcs[20], 32'd0);
    check("beq_nt_fetch", hist_addr[21], 32'h130);

    // ---- Directed: write bypass and writes to r0 ----
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
    rom[0] = enc_r(6'h20, 5'd6, 5'd5, 5'd0);    // add r6,r5,r0 : ID while r5 is written
    rom[1] = enc_r(6'h20, 5'd15, 5'd0, 5'd0);   // add r15,r0,r0 : ID while r0 is written
    rom[2] = enc_r(6'h20, 5'd16, 5'd5, 5'd0);   // add r16,r5,r0 : r5 now stored
    do_reset();
    step(1'b0, 0);
    force_wb = 1'b1; f_we = 1'b1; f_addr = 5'd5; f_data = 32'h0000_1234;
    step(1'b0, 1);
    f_addr = 5'd0; f_data = 32'hDEAD_BEEF;
    step(1'b0, 2);
    force_wb = 1'b0;
    for (int c = 3; c < 8; c++) step(1'b0, c);
    check("bypass_r5", hist_res[3], 32'h0000_1234);
    check("r0_write_ignored", hist_res[4], 32'd0);
    check("r5_stored", hist_res[5], 32'h0000_1234);

    // ---- Randomised program with random WB writes and occasional reset ----
    for (int i = 0; i < 256; i++) rom[i] = rand_instr();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      force_wb = ($urandom_range(0, 7) == 0);
      f_we     = 1'($urandom);
      f_addr   = 5'($urandom_range(0, 7));
      f_data   = $urandom;
      step($urandom_range(0, 299) == 0, -1);
    end
    force_wb = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
